stream_demux: RTL and testbench

- Registered 1-to-N stream demultiplexer; the steering counterpart of the CPU's N-to-1 one-hot mux.
- Accepts one valid/ready input stream tagged with a binary port select and delivers each beat to exactly one of num_port output ports.
- Uses a 2-entry main+skid buffer: full throughput with in_ready fully registered, so input and output handshakes have no combinational path between them.
- Used between a single producer (e.g. the memory response path) and multiple consumers.

---
 rtl/stream_demux_if.sv | 27 ++
 rtl/stream_demux.sv | 102 ++++++++++
 tb/tb_stream_demux.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_demux_if.sv
// Stream demux bus: one tagged valid/ready input stream, num_port valid/ready outputs sharing one data bus.
// The master modport is the surrounding environment; the slave modport is the demux itself.
interface stream_demux_if #(
    parameter int num_port   = 3,
    parameter int data_width = 32
);
    localparam int select_width = $clog2(num_port);

    logic                    in_valid;
    logic                    in_ready;
    logic [select_width-1:0] in_select;
    logic [data_width-1:0]   in_data;
    logic [num_port-1:0]     out_valid;
    logic [num_port-1:0]     out_ready;
    logic [data_width-1:0]   out_data;
    logic                    drop_err;

    modport master (
        output in_valid, in_select, in_data, out_ready,
        input  in_ready, out_valid, out_data, drop_err
    );

    modport slave (
        input  in_valid, in_select, in_data, out_ready,
        output in_ready, out_valid, out_data, drop_err
    );
endinterface

// File: rtl/stream_demux.sv
// Registered 1-to-N stream demux with main+skid buffer; beat visible one cycle after accept.
// Backpressure: in_ready is registered and drops only while the skid entry is occupied; strict FIFO, head-of-line blocking.
module stream_demux #(
    parameter int  num_port     = 3,
    parameter int  data_width   = 32,
    localparam int select_width = $clog2(num_port)
) (
    input  logic         clk,
    input  logic         reset,
    stream_demux_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [select_width:0] num_port_w = num_port[select_width:0];

    state_t                  state;
    logic [select_width-1:0] main_sel;
    logic [data_width-1:0]   main_data;
    logic [select_width-1:0] skid_sel;
    logic [data_width-1:0]   skid_data;
    logic                    in_ready_q;
    logic                    drop_q;

    logic                    main_valid;
    logic                    accept;
    logic                    sel_ok;
    logic                    store;
    logic                    fire;
    logic [num_port-1:0]     out_valid_d;

    assign main_valid = (state != EMPTY);
    assign accept     = bus.in_valid && bus.in_ready;
    assign sel_ok     = ({1'b0, bus.in_select} < num_port_w);
    // Out-of-range beats complete the handshake but never reach storage.
    assign store      = accept && sel_ok;
    assign fire       = main_valid && bus.out_ready[main_sel];

    always_comb begin
        out_valid_d = '0;
        if (main_valid) begin
            out_valid_d[main_sel] = 1'b1;
        end
    end

    assign bus.out_valid = out_valid_d;
    assign bus.out_data  = main_data;
    assign bus.in_ready  = in_ready_q && !reset;
    assign bus.drop_err  = drop_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            main_sel   <= '0;
            main_data  <= '0;
            skid_sel   <= '0;
            skid_data  <= '0;
            in_ready_q <= 1'b1;
            drop_q     <= 1'b0;
        end else begin
            drop_q <= accept && !sel_ok;
            case (state)
                EMPTY: begin
                    if (store) begin
                        main_sel  <= bus.in_select;
                        main_data <= bus.in_data;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (store && !fire) begin
                        skid_sel   <= bus.in_select;
                        skid_data  <= bus.in_data;
                        state      <= TWO;
                        in_ready_q <= 1'b0;
                    end else if (store) begin
                        main_sel  <= bus.in_select;
                        main_data <= bus.in_data;
                    end else if (fire) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    // No accept possible here; a fire promotes the skid beat to head.
                    if (fire) begin
                        main_sel   <= skid_sel;
                        main_data  <= skid_data;
                        state      <= ONE;
                        in_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_stream_demux.sv
// Self-checking bench for stream_demux: vector table, directed corner sequences, and a queue scoreboard
// that predicts head beat, in_ready and drop_err every cycle.
module tb_stream_demux;
    localparam int NP = 3;
    localparam int DW = 32;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
    } beat_t;

    typedef struct {
        logic [1:0]  sel;
        logic [31:0] data;
        logic [2:0]  exp_valid;
        logic        exp_drop;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_q = 1'b0;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   miss_cnt = 0;
    int   drop_cnt = 0;
    logic exp_drop = 1'b0;
    beat_t sb[$];

    stream_demux_if #(.num_port(NP), .data_width(DW)) bus ();

    stream_demux #(.num_port(NP), .data_width(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rst_q <= reset;
        cyc   <= cyc + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] oh(input logic [1:0] s);
        oh = 3'b001 << s;
    endfunction

    // Scoreboard: outputs at a negedge reflect accepts pushed at earlier negedges.
    always @(negedge clk) begin
        beat_t h;
        if (reset) begin
            chk("rst in_ready", {31'b0, bus.in_ready}, 32'd0);
            if (rst_q) begin
                chk("rst out_valid", {29'b0, bus.out_valid}, 32'd0);
                chk("rst out_data", bus.out_data, 32'd0);
                chk("rst drop_err", {31'b0, bus.drop_err}, 32'd0);
            end
            sb.delete();
            exp_drop = 1'b0;
        end else begin
            if (bus.drop_err) drop_cnt++;
            chk("drop_err", {31'b0, bus.drop_err}, {31'b0, exp_drop});
            chk("in_ready", {31'b0, bus.in_ready}, {31'b0, (sb.size() < 2)});
            if (sb.size() == 0) begin
                chk("idle out_valid", {29'b0, bus.out_valid}, 32'd0);
            end else begin
                h = sb[0];
                chk("head out_valid", {29'b0, bus.out_valid}, {29'b0, oh(h.sel)});
                chk("head out_data", bus.out_data, h.data);
                if (bus.out_ready[h.sel]) void'(sb.pop_front());
            end
            exp_drop = bus.in_valid && bus.in_ready && (bus.in_select >= 2'd3);
            if (bus.in_valid && bus.in_ready && bus.in_select < 2'd3) begin
                h.sel  = bus.in_select;
                h.data = bus.in_data;
                sb.push_back(h);
            end
        end
    end

    // Called just after a posedge; returns just after the accepting posedge with in_valid still high.
    task automatic send(input logic [1:0] sel, input logic [31:0] data);
        int n;
        bus.in_valid  = 1'b1;
        bus.in_select = sel;
        bus.in_data   = data;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) chk("send timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (sb.size() != 0) chk("drain timeout", sb.size(), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t vt[8];
        int   t0;
        int   d0;

        vt[0] = '{2'd2, 32'hDEADBEEF, 3'b100, 1'b0};
        vt[1] = '{2'd0, 32'h00000001, 3'b001, 1'b0};
        vt[2] = '{2'd1, 32'hA5A5A5A5, 3'b010, 1'b0};
        vt[3] = '{2'd3, 32'hBAD0BAD0, 3'b000, 1'b1};
        vt[4] = '{2'd1, 32'h12345678, 3'b010, 1'b0};
        vt[5] = '{2'd0, 32'hFFFFFFFF, 3'b001, 1'b0};
        vt[6] = '{2'd3, 32'h0BADF00D, 3'b000, 1'b1};
        vt[7] = '{2'd2, 32'h00000000, 3'b100, 1'b0};

        // Reset values, with in_valid held high throughout.
        bus.in_valid  = 1'b1;
        bus.in_select = 2'd0;
        bus.in_data   = 32'h55555555;
        bus.out_ready = 3'b000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1 out_valid", {29'b0, bus.out_valid}, 32'd0);
        chk("t1 out_data", bus.out_data, 32'd0);
        chk("t1 in_ready", {31'b0, bus.in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("t1 post in_ready", {31'b0, bus.in_ready}, 32'd1);
        chk("t1 post out_valid", {29'b0, bus.out_valid}, 32'd0);
        chk("t1 post out_data", bus.out_data, 32'd0);
        @(posedge clk);
        #1;

        // Vector table: single beats, all consumers ready.
        bus.out_ready = 3'b111;
        for (int i = 0; i < 8; i++) begin
            send(vt[i].sel, vt[i].data);
            bus.in_valid = 1'b0;
            @(negedge clk);
            chk("vec out_valid", {29'b0, bus.out_valid}, {29'b0, vt[i].exp_valid});
            chk("vec drop_err", {31'b0, bus.drop_err}, {31'b0, vt[i].exp_drop});
            if (vt[i].exp_valid != 3'b000) chk("vec out_data", bus.out_data, vt[i].data);
            @(negedge clk);
            chk("vec after out_valid", {29'b0, bus.out_valid}, 32'd0);
            chk("vec after drop_err", {31'b0, bus.drop_err}, 32'd0);
            @(posedge clk);
            #1;
        end

        // Backpressure: A and B fill both entries, C is held off.
        bus.out_ready = 3'b000;
        send(2'd0, 32'hAAAA0000);
        send(2'd1, 32'hBBBB1111);
        bus.in_select = 2'd2;
        bus.in_data   = 32'hCCCC2222;
        for (int i = 0; i < 4; i++) begin
            bus.out_ready = {i[0], 2'b00};
            @(negedge clk);
            chk("bp in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("bp out_valid", {29'b0, bus.out_valid}, 32'd1);
            chk("bp out_data", bus.out_data, 32'hAAAA0000);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 3'b001;
        @(posedge clk);
        #1;
        bus.out_ready = 3'b101;
        @(negedge clk);
        chk("bp B in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("bp B held", {29'b0, bus.out_valid}, 32'd2);
            chk("bp B data", bus.out_data, 32'hBBBB1111);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 3'b111;
        wait_drain();

        // Streaming: 16 beats back to back must take 16 cycles.
        t0 = cyc;
        for (int i = 0; i < 16; i++) send(2'(i % 3), 32'h1000 + i);
        bus.in_valid = 1'b0;
        chk("stream cycles", cyc - t0, 32'd16);
        wait_drain();

        // Out-of-range beats between two good ones, back to back.
        d0 = drop_cnt;
        send(2'd0, 32'h0000AAAA);
        send(2'd3, 32'hDEAD0003);
        send(2'd3, 32'hDEAD0004);
        send(2'd1, 32'h0000BBBB);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("oor B next", {29'b0, bus.out_valid}, 32'd2);
        chk("oor B data", bus.out_data, 32'h0000BBBB);
        wait_drain();
        repeat (2) @(posedge clk);
        #1;
        chk("oor drop pulses", drop_cnt - d0, 32'd2);

        // Reset while both entries are held.
        bus.out_ready = 3'b000;
        send(2'd0, 32'h11110000);
        send(2'd2, 32'h22220000);
        bus.in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("mid rst out_valid", {29'b0, bus.out_valid}, 32'd0);
        chk("mid rst in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.out_ready = 3'b111;
        send(2'd1, 32'h33330001);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid rst new valid", {29'b0, bus.out_valid}, 32'd2);
        chk("mid rst new data", bus.out_data, 32'h33330001);
        @(negedge clk);
        chk("mid rst alone", {29'b0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
